// File: rtl/privilege_guard.sv
// privilege_guard: kernel/user ring monitor that latches the first privilege violation and halts the CPU.
module privilege_guard #(
   parameter logic [15:0] RING0_LAST     = 16'hFFFF,
   parameter logic [15:0] RING0_ENTRY    = 16'h0000,
   parameter logic [15:0] RING0_MEM_LAST = 16'h0000,
   parameter logic [4:0]  RING0_REG_LAST = 5'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_instrValid,
   input  logic [15:0] io_programCounter,
   input  logic        io_jump,
   input  logic [15:0] io_programCounterJump,
   input  logic        io_dataMemEnable,
   input  logic [15:0] io_dataAddress,
   input  logic [4:0]  io_aSel,
   input  logic [4:0]  io_bSel,
   input  logic        io_writeEnable,
   input  logic [4:0]  io_writeSel,
   input  logic [31:0] io_syscallReg,
   output logic [15:0] io_programMemoryOffset,
   output logic [15:0] io_dataMemoryOffset,
   output logic        io_privileged,
   output logic        io_fault,
   output logic [2:0]  io_faultCode,
   output logic [15:0] io_faultAddr,
   output logic        io_halt,
   output logic [15:0] io_syscallCount
);
   typedef enum logic [1:0] {KERNEL, USER, FAULT} state_t;
   localparam logic [15:0] OFFSET = RING0_LAST + 16'd1;
   state_t state;
   logic user, active, syscall, entry, viol;
   logic [2:0] code;
   assign user    = io_programCounter > RING0_LAST;
   assign active  = io_instrValid && user && state != FAULT;
   assign syscall = io_syscallReg != 32'd0;
   assign entry   = active && io_jump && io_programCounterJump == RING0_ENTRY;
   // Lowest code wins when several violations coincide
   always_comb begin
      code = 3'd0;
      if (active)
         code = (io_jump && io_programCounterJump <= RING0_LAST &&
                 io_programCounterJump != RING0_ENTRY && !syscall) ? 3'd1 :
                (io_dataMemEnable && io_dataAddress <= RING0_MEM_LAST) ? 3'd2 :
                (io_aSel <= RING0_REG_LAST) ? 3'd3 :
                (io_bSel <= RING0_REG_LAST) ? 3'd4 :
                (io_writeEnable && io_writeSel <= RING0_REG_LAST) ? 3'd5 : 3'd0;
   end
   assign viol          = code != 3'd0;
   assign io_privileged = state == KERNEL;
   always_ff @(posedge clock) begin
      if (reset) begin
         state                  <= KERNEL;
         io_programMemoryOffset <= '0;
         io_dataMemoryOffset    <= '0;
         io_fault               <= 1'b0;
         io_halt                <= 1'b0;
         io_faultCode           <= '0;
         io_faultAddr           <= '0;
         io_syscallCount        <= '0;
      end else if (io_instrValid && state != FAULT) begin
         state                  <= viol ? FAULT : user ? USER : KERNEL;
         io_programMemoryOffset <= (user && !syscall) ? OFFSET : 16'd0;
         io_dataMemoryOffset    <= user ? OFFSET : 16'd0;
         if (viol) begin
            io_fault     <= 1'b1;
            io_halt      <= 1'b1;
            io_faultCode <= code;
            io_faultAddr <= io_programCounter;
         end
         if (entry && !viol && io_syscallCount != 16'hFFFF)
            io_syscallCount <= io_syscallCount + 16'd1;
      end
   end
endmodule

// File: tb/tb_privilege_guard.sv
// tb_privilege_guard: directed scenarios for privilege_guard with hand-computed expectations.
module tb_privilege_guard;
   logic        clock = 1'b0, reset = 1'b0;
   logic        io_instrValid, io_jump, io_dataMemEnable, io_writeEnable;
   logic [15:0] io_programCounter, io_programCounterJump, io_dataAddress;
   logic [4:0]  io_aSel, io_bSel, io_writeSel;
   logic [31:0] io_syscallReg;
   logic [15:0] io_programMemoryOffset, io_dataMemoryOffset, io_faultAddr, io_syscallCount;
   logic        io_privileged, io_fault, io_halt;
   logic [2:0]  io_faultCode;
   int vectors = 0, miscompares = 0;

   privilege_guard #(.RING0_LAST(16'h00FF), .RING0_ENTRY(16'h0000),
                     .RING0_MEM_LAST(16'h000F), .RING0_REG_LAST(5'd0)) dut (
      .clock(clock), .reset(reset), .io_instrValid(io_instrValid),
      .io_programCounter(io_programCounter), .io_jump(io_jump),
      .io_programCounterJump(io_programCounterJump), .io_dataMemEnable(io_dataMemEnable),
      .io_dataAddress(io_dataAddress), .io_aSel(io_aSel), .io_bSel(io_bSel),
      .io_writeEnable(io_writeEnable), .io_writeSel(io_writeSel), .io_syscallReg(io_syscallReg),
      .io_programMemoryOffset(io_programMemoryOffset), .io_dataMemoryOffset(io_dataMemoryOffset),
      .io_privileged(io_privileged), .io_fault(io_fault), .io_faultCode(io_faultCode),
      .io_faultAddr(io_faultAddr), .io_halt(io_halt), .io_syscallCount(io_syscallCount));

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Benign instruction: register selects kept away from the privileged index 0
   task automatic idle(input logic [15:0] pc);
      io_instrValid = 1'b1; io_programCounter = pc; io_jump = 1'b0; io_programCounterJump = 16'h0;
      io_dataMemEnable = 1'b0; io_dataAddress = 16'h0; io_aSel = 5'd1; io_bSel = 5'd2;
      io_writeEnable = 1'b0; io_writeSel = 5'd3; io_syscallReg = 32'd0;
   endtask

   task automatic check_cleared(input string tag);
      vectors++; if (io_privileged !== 1'b1) begin miscompares++; $display("FAIL %s privileged got %b want 1", tag, io_privileged); end
      vectors++; if (io_programMemoryOffset !== 16'h0 || io_dataMemoryOffset !== 16'h0) begin miscompares++; $display("FAIL %s offsets got %h/%h want 0/0", tag, io_programMemoryOffset, io_dataMemoryOffset); end
      vectors++; if ({io_fault, io_halt, io_faultCode} !== 5'b0) begin miscompares++; $display("FAIL %s fault/halt/code got %b%b%0d want 000", tag, io_fault, io_halt, io_faultCode); end
      vectors++; if (io_faultAddr !== 16'h0 || io_syscallCount !== 16'h0) begin miscompares++; $display("FAIL %s addr/count got %h/%h want 0/0", tag, io_faultAddr, io_syscallCount); end
   endtask

   task automatic do_reset();
      reset = 1'b1; step(); reset = 1'b0;
   endtask

   task automatic test_reset();
      idle(16'h0010); do_reset();
      check_cleared("reset");
   endtask

   task automatic test_kernel();
      idle(16'h0010); io_aSel = 5'd0;
      repeat (3) step();
      check_cleared("kernel");
   endtask

   task automatic test_user_entry();
      idle(16'h0100); step();
      vectors++; if (io_privileged !== 1'b0) begin miscompares++; $display("FAIL user_priv got %b want 0", io_privileged); end
      vectors++; if (io_programMemoryOffset !== 16'h0100) begin miscompares++; $display("FAIL user_pmo got %h want 0100", io_programMemoryOffset); end
      vectors++; if (io_dataMemoryOffset !== 16'h0100) begin miscompares++; $display("FAIL user_dmo got %h want 0100", io_dataMemoryOffset); end
      idle(16'h0010); io_instrValid = 1'b0; io_aSel = 5'd0; io_dataMemEnable = 1'b1; step();
      vectors++; if (io_privileged !== 1'b0 || io_programMemoryOffset !== 16'h0100 || io_fault !== 1'b0) begin miscompares++; $display("FAIL invalid_hold got priv=%b pmo=%h fault=%b want 0/0100/0", io_privileged, io_programMemoryOffset, io_fault); end
   endtask

   task automatic test_syscall();
      do_reset();
      idle(16'h0130); io_jump = 1'b1; io_programCounterJump = 16'h0000; io_syscallReg = 32'd5; step();
      vectors++; if (io_fault !== 1'b0 || io_syscallCount !== 16'd1) begin miscompares++; $display("FAIL syscall got fault=%b count=%0d want 0/1", io_fault, io_syscallCount); end
      vectors++; if (io_programMemoryOffset !== 16'h0 || io_dataMemoryOffset !== 16'h0100) begin miscompares++; $display("FAIL syscall_offs got %h/%h want 0000/0100", io_programMemoryOffset, io_dataMemoryOffset); end
      idle(16'h0000); step();
      vectors++; if (io_privileged !== 1'b1 || io_dataMemoryOffset !== 16'h0 || io_syscallCount !== 16'd1) begin miscompares++; $display("FAIL syscall_return got priv=%b dmo=%h count=%0d want 1/0000/1", io_privileged, io_dataMemoryOffset, io_syscallCount); end
   endtask

   task automatic test_jump_fault();
      do_reset();
      idle(16'h0120); io_jump = 1'b1; io_programCounterJump = 16'h0040; step();
      vectors++; if ({io_fault, io_halt} !== 2'b11 || io_faultCode !== 3'd1 || io_faultAddr !== 16'h0120) begin miscompares++; $display("FAIL jump_fault got %b%b code=%0d addr=%h want 11/1/0120", io_fault, io_halt, io_faultCode, io_faultAddr); end
      vectors++; if (io_privileged !== 1'b0 || io_syscallCount !== 16'd0) begin miscompares++; $display("FAIL jump_fault_misc got priv=%b count=%0d want 0/0", io_privileged, io_syscallCount); end
      idle(16'h0150); io_dataMemEnable = 1'b1; io_aSel = 5'd0; step();
      idle(16'h0010); step();
      vectors++; if (io_faultCode !== 3'd1 || io_faultAddr !== 16'h0120 || io_fault !== 1'b1) begin miscompares++; $display("FAIL jump_sticky got code=%0d addr=%h fault=%b want 1/0120/1", io_faultCode, io_faultAddr, io_fault); end
      vectors++; if (io_privileged !== 1'b0 || io_programMemoryOffset !== 16'h0100 || io_dataMemoryOffset !== 16'h0100) begin miscompares++; $display("FAIL fault_hold got priv=%b offs=%h/%h want 0/0100/0100", io_privileged, io_programMemoryOffset, io_dataMemoryOffset); end
   endtask

   task automatic test_mem_priority();
      do_reset();
      idle(16'h0140); io_dataMemEnable = 1'b1; io_dataAddress = 16'h0008; io_aSel = 5'd0; step();
      vectors++; if (io_faultCode !== 3'd2 || io_faultAddr !== 16'h0140 || io_fault !== 1'b1) begin miscompares++; $display("FAIL mem_prio got code=%0d addr=%h fault=%b want 2/0140/1", io_faultCode, io_faultAddr, io_fault); end
      idle(16'h0160); io_writeEnable = 1'b1; io_writeSel = 5'd0; repeat (2) step();
      vectors++; if (io_faultCode !== 3'd2 || io_halt !== 1'b1) begin miscompares++; $display("FAIL mem_sticky got code=%0d halt=%b want 2/1", io_faultCode, io_halt); end
   endtask

   task automatic test_reg_codes();
      do_reset();
      idle(16'h0170); io_bSel = 5'd0; io_writeEnable = 1'b1; io_writeSel = 5'd0; step();
      vectors++; if (io_faultCode !== 3'd4) begin miscompares++; $display("FAIL bsel_code got %0d want 4", io_faultCode); end
      do_reset();
      idle(16'h0180); io_writeEnable = 1'b1; io_writeSel = 5'd0; io_dataMemEnable = 1'b1; io_dataAddress = 16'h0010; step();
      vectors++; if (io_faultCode !== 3'd5 || io_faultAddr !== 16'h0180) begin miscompares++; $display("FAIL wsel_code got %0d addr=%h want 5/0180", io_faultCode, io_faultAddr); end
   endtask

   task automatic test_reset_in_fault();
      idle(16'h0190); io_aSel = 5'd0; reset = 1'b1; step(); reset = 1'b0;
      check_cleared("reset_in_fault");
   endtask

   initial begin
      idle(16'h0010);
      test_reset();
      test_kernel();
      test_user_entry();
      test_syscall();
      test_jump_fault();
      test_mem_priority();
      test_reg_codes();
      test_reset_in_fault();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
